// File: rtl/piso_buffer_pkg.sv
`default_nettype none
// ============================================================================
// piso_buffer_pkg : shared SHAKE output-path constants and PISO state encoding
// Rev 1.0
// ============================================================================
package piso_buffer_pkg;

  localparam int unsigned SHAKE_WIDTH = 64;
  localparam int unsigned SHAKE_DEPTH = 25;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/piso_buffer.sv
`default_nettype none
// ============================================================================
// piso_buffer : parallel-in serial-out buffer, MSB slot emitted first
// Rev 1.0
// ============================================================================
module piso_buffer
  import piso_buffer_pkg::*;
#(
  parameter int WIDTH = SHAKE_WIDTH,
  parameter int DEPTH = SHAKE_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic [DEPTH*WIDTH-1:0] data_i,
  input  logic [CNT_W-1:0]       count_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o
);

  state_e                 state_q;
  logic [DEPTH*WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0]       rem_q;
  logic                   valid_q;
  logic                   last_q;

  logic [CNT_W-1:0]       eff_cnt;
  logic                   beat_fire;
  logic                   last_fire;
  logic                   load_fire;

  // Zero and out-of-range counts both mean "emit the whole word".
  always_comb begin
    eff_cnt = count_i;
    if (count_i == '0 || count_i > CNT_W'(DEPTH)) begin
      eff_cnt = CNT_W'(DEPTH);
    end
  end

  assign beat_fire    = valid_q && ready_i;
  assign last_fire    = beat_fire && last_q;
  assign load_ready_o = (state_q == IDLE) || last_fire;
  assign load_fire    = load_valid_i && load_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_fire) begin
      state_q <= SHIFT;
      shreg_q <= data_i;
      rem_q   <= eff_cnt;
      valid_q <= 1'b1;
      last_q  <= (eff_cnt == CNT_W'(1));
    end else if (last_fire) begin
      // Clearing the word keeps data_o at zero while idle.
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (beat_fire) begin
      shreg_q <= shreg_q << WIDTH;
      rem_q   <= rem_q - CNT_W'(1);
      last_q  <= (rem_q == CNT_W'(2));
    end
  end

  assign data_o  = shreg_q[DEPTH*WIDTH-1 -: WIDTH];
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_buffer.sv
`default_nettype none
// ============================================================================
// tb_piso_buffer : directed checks of piso_buffer with WIDTH=8, DEPTH=4
// Rev 1.0
// ============================================================================
module tb_piso_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   load_valid_i;
  logic                   load_ready_o;
  logic [DEPTH*WIDTH-1:0] data_i;
  logic [CNT_W-1:0]       count_i;
  logic [WIDTH-1:0]       data_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   last_o;

  int vectors = 0;
  int errors  = 0;

  piso_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .data_i       (data_i),
    .count_i      (count_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic l);
    chk({tag, ".valid"}, 32'(valid_o), 32'd1);
    chk({tag, ".data"},  32'(data_o),  32'(d));
    chk({tag, ".last"},  32'(last_o),  32'(l));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(valid_o),      32'd0);
    chk({tag, ".last"},  32'(last_o),       32'd0);
    chk({tag, ".data"},  32'(data_o),       32'd0);
    chk({tag, ".lrdy"},  32'(load_ready_o), 32'd1);
  endtask

  // Presents a word for one edge from IDLE; first beat is visible on return.
  task automatic load(input logic [31:0] w, input logic [2:0] c);
    load_valid_i = 1'b1;
    data_i       = w;
    count_i      = c;
    tick();
    load_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] sipo;
    int          beats;
    int          budget;

    rst = 1'b1; load_valid_i = 1'b0; data_i = '0; count_i = '0; ready_i = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_idle("reset");

    // Full word, no backpressure
    load(32'hA1B2C3D4, 3'd4);
    chk_beat("full.b0", 8'hA1, 1'b0);
    chk("full.lrdy_busy", 32'(load_ready_o), 32'd0);
    tick(); chk_beat("full.b1", 8'hB2, 1'b0);
    tick(); chk_beat("full.b2", 8'hC3, 1'b0);
    tick(); chk_beat("full.b3", 8'hD4, 1'b1);
    chk("full.lrdy_last", 32'(load_ready_o), 32'd1);
    tick(); chk_idle("full.after");

    // Partial count
    load(32'h11223344, 3'd2);
    chk_beat("part.b0", 8'h11, 1'b0);
    tick(); chk_beat("part.b1", 8'h22, 1'b1);
    tick(); chk_idle("part.after");

    // count 0 and count 7 both mean four beats
    load(32'h01020304, 3'd0);
    chk_beat("cnt0.b0", 8'h01, 1'b0);
    tick(); chk_beat("cnt0.b1", 8'h02, 1'b0);
    tick(); chk_beat("cnt0.b2", 8'h03, 1'b0);
    tick(); chk_beat("cnt0.b3", 8'h04, 1'b1);
    tick(); chk_idle("cnt0.after");

    load(32'hF1E2D3C4, 3'd7);
    chk_beat("cnt7.b0", 8'hF1, 1'b0);
    tick(); chk_beat("cnt7.b1", 8'hE2, 1'b0);
    tick(); chk_beat("cnt7.b2", 8'hD3, 1'b0);
    tick(); chk_beat("cnt7.b3", 8'hC4, 1'b1);
    tick(); chk_idle("cnt7.after");

    // Backpressure on B2, then back-to-back load on the D4 handshake
    load(32'hA1B2C3D4, 3'd4);
    chk_beat("bp.b0", 8'hA1, 1'b0);
    tick(); chk_beat("bp.b1", 8'hB2, 1'b0);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.lrdy", 32'(load_ready_o), 32'd0);
      tick(); chk_beat("bp.hold", 8'hB2, 1'b0);
    end
    ready_i = 1'b1;
    tick(); chk_beat("bp.b2", 8'hC3, 1'b0);
    tick(); chk_beat("bp.b3", 8'hD4, 1'b1);
    load_valid_i = 1'b1; data_i = 32'h55667788; count_i = 3'd4;
    #1 chk("b2b.lrdy", 32'(load_ready_o), 32'd1);
    tick(); chk_beat("b2b.n0", 8'h55, 1'b0);
    data_i = 32'h99AABBCC;
    #1 chk("b2b.lrdy_busy", 32'(load_ready_o), 32'd0);
    tick(); chk_beat("b2b.n1", 8'h66, 1'b0);
    load_valid_i = 1'b0;
    tick(); chk_beat("b2b.n2", 8'h77, 1'b0);
    tick(); chk_beat("b2b.n3", 8'h88, 1'b1);
    tick(); chk_idle("b2b.after");

    // Reset in the middle of a word
    load(32'hA1B2C3D4, 3'd4);
    tick(); chk_beat("rst.b1", 8'hB2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst.after");
    load(32'hDEADBEEF, 3'd4);
    chk_beat("rst.new", 8'hDE, 1'b0);
    tick(); tick(); tick(); tick();
    chk_idle("rst.drain");

    // Round trip through a shift-in reconstruction with random backpressure
    for (int n = 0; n < 6; n++) begin
      word = $urandom;
      load(word, 3'd4);
      sipo   = '0;
      beats  = 0;
      budget = 60;
      while (beats < 4 && budget > 0) begin
        ready_i = 1'($urandom_range(0, 1));
        #1;
        if (valid_o && ready_i) begin
          sipo = {sipo[23:0], data_o};
          beats++;
          if (beats == 4) chk("rt.last", 32'(last_o), 32'd1);
        end
        tick();
        budget--;
      end
      chk("rt.beats", 32'(beats), 32'd4);
      chk("rt.word", sipo, word);
      ready_i = 1'b1;
      chk_idle("rt.after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_buffer.md
Name: piso_buffer

Overview:
- Parallel-in serial-out buffer. Inverse of the team's sipo_buffer.
- Accepts one DEPTH*WIDTH-bit word, such as a squeezed Keccak state slice, over a valid/ready load handshake.
- Emits the word as up to DEPTH beats of WIDTH bits over a valid/ready stream. It feeds the SHAKE output path so that a sipo_buffer at the far end reconstructs the original word.

Parameters:
- WIDTH, 64, width of one serial beat in bits.
- DEPTH, 25, number of WIDTH-bit slots in the parallel word.
- CNT_W, $clog2(DEPTH+1), width of the beat-count input (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load_valid_i  input  1  parallel word and count are valid.
- load_ready_o  output  1  block can accept a parallel word this cycle.
- data_i  input  DEPTH*WIDTH  parallel word; slot k = data_i[(k+1)*WIDTH-1 -: WIDTH].
- count_i  input  CNT_W  number of beats to emit for this word.
- data_o  output  WIDTH  current serial beat.
- valid_o  output  1  data_o holds a valid beat.
- ready_i  input  1  downstream accepts the beat.
- last_o  output  1  current beat is the final beat of this word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - valid_o=0, last_o=0, data_o=0.
  - Internal beat counter=0, state=IDLE.
  - load_ready_o=1 after reset.
- Beat order:
  - Slot DEPTH-1 (MSBs) is emitted first, then DEPTH-2, and so on down.
  - This matches the sipo_buffer ordering: first-shifted-in beat lands in the MSB slot.
- Count rules:
  - count_i=0 is treated as DEPTH.
  - count_i>DEPTH saturates to DEPTH.
  - With effective count n, slots DEPTH-1 down to DEPTH-n are emitted. Lower slots are discarded.
- States:
  - IDLE: valid_o=0, load_ready_o=1.
    - A load handshake (load_valid_i && load_ready_o) captures data_i and the effective count.
    - Next cycle: state SHIFT, valid_o=1, data_o=slot DEPTH-1. Load-to-first-beat latency is 1 cycle.
  - SHIFT: valid_o=1.
    - A beat handshake (valid_o && ready_i) advances: the word shifts up by WIDTH and the remaining count decrements.
    - Next cycle, data_o shows the next slot.
    - last_o=1 exactly while remaining count==1.
    - A handshake with last_o=1 returns the block to IDLE unless a simultaneous load occurs (see below).
- Simultaneous last-beat and load:
  - load_ready_o = (state==IDLE) || (valid_o && ready_i && last_o). This path is combinational from ready_i.
  - If a load is accepted in the same cycle as the last beat, the next cycle shows beat 0 of the new word with valid_o=1. There is no bubble, giving 100% throughput.
- Backpressure:
  - While valid_o && !ready_i, data_o, last_o and valid_o hold stable.
  - load_ready_o=0 unless the last-beat condition above applies.
- Load ignored: load_valid_i in SHIFT without the last-beat condition has no effect; the word is not captured.
- Reset mid-operation: rst in any state returns the block to reset values next cycle. The in-flight word is dropped with no further beats.
- No X propagation: data_o=0 whenever valid_o=0.

Decomposition:
- Shared package (e.g. shake_pkg): shared WIDTH/DEPTH constants (64, 25) and the state enum {IDLE, SHIFT}.
- Sub-module: none. Single module with a shift register, a down-counter and a 2-state FSM.

Test Plan (WIDTH=8, DEPTH=4):
- Full word: load data_i=32'hA1B2C3D4, count_i=4, ready_i=1.
  - Required: beats A1, B2, C3, D4 on 4 consecutive cycles, starting 1 cycle after load.
  - last_o=1 only on D4; load_ready_o=1 the cycle after D4.
- Partial and saturation:
  - count_i=2 on 32'h11223344 -> beats 11, 22; last on 22.
  - count_i=0 -> 4 beats.
  - count_i=7 -> 4 beats.
- Backpressure: ready_i=0 for 3 cycles on beat B2.
  - Required: data_o=B2, valid_o=1 and last_o=0 stable throughout; the next beat C3 appears only after ready_i returns to 1.
- Back-to-back: load_valid_i held with a second word 32'h55667788 during the D4 handshake.
  - Required: next cycle data_o=55, valid_o=1, with no idle cycle.
  - During SHIFT with no last beat, the held load is not accepted.
- Reset: assert rst during beat B2.
  - Required next cycle: valid_o=0, last_o=0, data_o=0, load_ready_o=1.
  - A new load emits from its own slot 3.
- Round-trip: chain into sipo_buffer (en = valid_o && ready_i) with random words and count=4.
  - Required: sipo data_o equals the loaded word after every 4 beats.
